idu_imm_stage: RTL

IDU_IMM_STAGE -- requirements
Module: idu_imm_stage

---
 rtl/npc_pkg.sv | 44 ++++
 rtl/idu_imm_extract.sv | 44 ++++
 rtl/idu_imm_stage.sv | 120 ++++++++++++
 3 files changed

// File: rtl/npc_pkg.sv
// Shared decode types for the immediate stage: opcode constants, extop codes,
// and the per-instruction entry record held by the register stage.
package npc_pkg;

  localparam logic [6:0] OP_LOAD   = 7'h03;
  localparam logic [6:0] OP_OPIMM  = 7'h13;
  localparam logic [6:0] OP_JALR   = 7'h67;
  localparam logic [6:0] OP_SYSTEM = 7'h73;
  localparam logic [6:0] OP_FENCE  = 7'h0F;
  localparam logic [6:0] OP_STORE  = 7'h23;
  localparam logic [6:0] OP_BRANCH = 7'h63;
  localparam logic [6:0] OP_JAL    = 7'h6F;
  localparam logic [6:0] OP_LUI    = 7'h37;
  localparam logic [6:0] OP_AUIPC  = 7'h17;
  localparam logic [6:0] OP_OP     = 7'h33;

  typedef enum logic [3:0] {
    EXT_LOAD   = 4'h0,
    EXT_OPIMM  = 4'h1,
    EXT_JALR   = 4'h2,
    EXT_SYSTEM = 4'h3,
    EXT_FENCE  = 4'h4,
    EXT_STORE  = 4'h5,
    EXT_BRANCH = 4'h6,
    EXT_JAL    = 4'h7,
    EXT_LUI    = 4'h8,
    EXT_AUIPC  = 4'h9,
    EXT_RTYPE  = 4'hA,
    EXT_ILL    = 4'hF
  } extop_e;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
    extop_e      extop;
    logic        illegal;
    logic [31:0] imm_i;
    logic [31:0] imm_s;
    logic [31:0] imm_b;
    logic [31:0] imm_j;
    logic [31:0] imm_u;
  } imm_entry_t;

endpackage

// File: rtl/idu_imm_extract.sv
// Purely combinational RV32I field extraction: opcode -> extop code plus all
// five sign-extended immediate formats, computed unconditionally.
module idu_imm_extract
  import npc_pkg::*;
(
  input  logic [31:0] in_inst,
  output extop_e      out_extop,
  output logic        out_illegal,
  output logic [31:0] out_immI,
  output logic [31:0] out_immS,
  output logic [31:0] out_immB,
  output logic [31:0] out_immJ,
  output logic [31:0] out_immU
);

  always_comb begin
    out_extop = EXT_ILL;
    case (in_inst[6:0])
      OP_LOAD:   out_extop = EXT_LOAD;
      OP_OPIMM:  out_extop = EXT_OPIMM;
      OP_JALR:   out_extop = EXT_JALR;
      OP_SYSTEM: out_extop = EXT_SYSTEM;
      OP_FENCE:  out_extop = EXT_FENCE;
      OP_STORE:  out_extop = EXT_STORE;
      OP_BRANCH: out_extop = EXT_BRANCH;
      OP_JAL:    out_extop = EXT_JAL;
      OP_LUI:    out_extop = EXT_LUI;
      OP_AUIPC:  out_extop = EXT_AUIPC;
      OP_OP:     out_extop = EXT_RTYPE;
      default:   out_extop = EXT_ILL;
    endcase
  end

  assign out_illegal = (out_extop == EXT_ILL);

  assign out_immI = {{20{in_inst[31]}}, in_inst[31:20]};
  assign out_immS = {{20{in_inst[31]}}, in_inst[31:25], in_inst[11:7]};
  assign out_immB = {{19{in_inst[31]}}, in_inst[31], in_inst[7], in_inst[30:25],
                     in_inst[11:8], 1'b0};
  assign out_immJ = {{11{in_inst[31]}}, in_inst[31], in_inst[19:12], in_inst[20],
                     in_inst[30:21], 1'b0};
  assign out_immU = {in_inst[31:12], 12'b0};

endmodule

// File: rtl/idu_imm_stage.sv
// Decode/immediate pipeline stage with valid/ready handshake on both sides.
// IDU_IMM_SKID_EN selects a two-entry skid buffer with registered in_ready.
module idu_imm_stage
  import npc_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [XLEN-1:0] in_pc,
  input  logic [XLEN-1:0] in_inst,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_pc,
  output logic [XLEN-1:0] out_inst,
  output logic [3:0]      out_extop,
  output logic [XLEN-1:0] out_immI,
  output logic [XLEN-1:0] out_immS,
  output logic [XLEN-1:0] out_immB,
  output logic [XLEN-1:0] out_immJ,
  output logic [XLEN-1:0] out_immU,
  output logic            out_illegal
);

  imm_entry_t w_new;
  imm_entry_t r_main;
  logic       r_valid;
  logic       w_in_fire;

  extop_e      w_extop;
  logic        w_illegal;
  logic [31:0] w_imm_i, w_imm_s, w_imm_b, w_imm_j, w_imm_u;

  idu_imm_extract u_extract (
    .in_inst     (in_inst),
    .out_extop   (w_extop),
    .out_illegal (w_illegal),
    .out_immI    (w_imm_i),
    .out_immS    (w_imm_s),
    .out_immB    (w_imm_b),
    .out_immJ    (w_imm_j),
    .out_immU    (w_imm_u)
  );

  always_comb begin
    w_new         = '0;
    w_new.pc      = in_pc;
    w_new.inst    = in_inst;
    w_new.extop   = w_extop;
    w_new.illegal = w_illegal;
    w_new.imm_i   = w_imm_i;
    w_new.imm_s   = w_imm_s;
    w_new.imm_b   = w_imm_b;
    w_new.imm_j   = w_imm_j;
    w_new.imm_u   = w_imm_u;
  end

  assign w_in_fire = in_valid && in_ready;

`ifdef IDU_IMM_SKID_EN
  imm_entry_t r_skid;
  logic       r_skid_valid;

  // in_ready comes straight from a flop, breaking the out_ready->in_ready path.
  assign in_ready = !r_skid_valid;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid      <= 1'b0;
      r_skid_valid <= 1'b0;
      r_main       <= '0;
      r_skid       <= '0;
    end else if (flush) begin
      r_valid      <= 1'b0;
      r_skid_valid <= 1'b0;
    end else if (!r_valid || out_ready) begin
      if (r_skid_valid) begin
        r_main       <= r_skid;
        r_valid      <= 1'b1;
        r_skid_valid <= 1'b0;
      end else begin
        r_valid <= w_in_fire;
        if (w_in_fire) r_main <= w_new;
      end
    end else if (w_in_fire) begin
      r_skid       <= w_new;
      r_skid_valid <= 1'b1;
    end
  end
`else
  assign in_ready = !r_valid || out_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid <= 1'b0;
      r_main  <= '0;
    end else if (flush) begin
      r_valid <= 1'b0;
    end else if (in_ready) begin
      r_valid <= in_valid;
      if (in_valid) r_main <= w_new;
    end
  end
`endif

  assign out_valid   = r_valid;
  assign out_pc      = r_main.pc;
  assign out_inst    = r_main.inst;
  assign out_extop   = r_main.extop;
  assign out_illegal = r_main.illegal;
  assign out_immI    = r_main.imm_i;
  assign out_immS    = r_main.imm_s;
  assign out_immB    = r_main.imm_b;
  assign out_immJ    = r_main.imm_j;
  assign out_immU    = r_main.imm_u;

endmodule
